// File: rtl/common.sv
// Shared RV32I types: raw instruction layout and the decoded control record.
// Used by the decode queue stage and anything downstream of it.
package common;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_type;

    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE,
        S_TYPE,
        B_TYPE,
        J_TYPE,
        U_TYPE
    } encoding_type;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_LUI,
        B_BNE,
        B_BLT,
        B_BGE,
        B_LTU,
        B_GEU,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_type;

    typedef struct packed {
        encoding_type encoding;
        alu_op_type   alu_op;
        logic         alu_src;
        logic         mem_read;
        logic         mem_write;
        logic         mem_to_reg;
        logic         reg_write;
        logic         is_branch;
    } control_type;

endpackage

// File: rtl/decode_queue_stage.sv
// RV32I decode stage feeding execute through a DEPTH-entry decoded FIFO.
// Optional RV32M decode is enabled by defining RV32M_EN.
module decode_queue_stage
    import common::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_pc,
    output control_type                out_control,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef RV32M_EN
    localparam logic [6:0] F7_MUL  = 7'b0000001;
`endif

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        control_type     ctrl;
        logic            ill;
    } entry_t;

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    control_type dec_ctrl;
    logic        dec_ill;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;
    entry_t           head;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    function automatic alu_op_type alu_base(input logic [2:0] f3);
        alu_op_type op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

`ifdef RV32M_EN
    function automatic alu_op_type alu_mul(input logic [2:0] f3);
        alu_op_type op;
        case (f3)
            3'b000:  op = ALU_MUL;
            3'b001:  op = ALU_MULH;
            3'b010:  op = ALU_MULHSU;
            3'b011:  op = ALU_MULHU;
            3'b100:  op = ALU_DIV;
            3'b101:  op = ALU_DIVU;
            3'b110:  op = ALU_REM;
            default: op = ALU_REMU;
        endcase
        return op;
    endfunction
`endif

    function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decode the incoming instruction; illegal encodings carry an all-zero record.
    always_comb begin
        dec_ctrl = '0;
        dec_ill  = 1'b0;
        unique case (1'b1)
            (opcode == OP_R): begin
                dec_ctrl.encoding  = R_TYPE;
                dec_ctrl.reg_write = 1'b1;
                if (funct7 == F7_BASE)
                    dec_ctrl.alu_op = alu_base(funct3);
                else if (funct7 == F7_ALT && funct3 == 3'b000)
                    dec_ctrl.alu_op = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101)
                    dec_ctrl.alu_op = ALU_SRA;
`ifdef RV32M_EN
                else if (funct7 == F7_MUL)
                    dec_ctrl.alu_op = alu_mul(funct3);
`endif
                else
                    dec_ill = 1'b1;
            end
            (opcode == OP_I): begin
                dec_ctrl.encoding  = I_TYPE;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = alu_base(funct3);
                if (funct3 == 3'b001 && funct7 != F7_BASE)
                    dec_ill = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)
                        dec_ctrl.alu_op = ALU_SRA;
                    else if (funct7 != F7_BASE)
                        dec_ill = 1'b1;
                end
            end
            (opcode == OP_LOAD): begin
                dec_ctrl.encoding   = I_TYPE;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_op     = ALU_ADD;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    dec_ill = 1'b1;
            end
            (opcode == OP_STORE): begin
                dec_ctrl.encoding  = S_TYPE;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
                if (funct3 >= 3'b011)
                    dec_ill = 1'b1;
            end
            (opcode == OP_BRANCH): begin
                dec_ctrl.encoding  = B_TYPE;
                dec_ctrl.is_branch = 1'b1;
                case (funct3)
                    3'b000:  dec_ctrl.alu_op = ALU_SUB;
                    3'b001:  dec_ctrl.alu_op = B_BNE;
                    3'b100:  dec_ctrl.alu_op = B_BLT;
                    3'b101:  dec_ctrl.alu_op = B_BGE;
                    3'b110:  dec_ctrl.alu_op = B_LTU;
                    3'b111:  dec_ctrl.alu_op = B_GEU;
                    default: dec_ill = 1'b1;
                endcase
            end
            (opcode == OP_JAL): begin
                dec_ctrl.encoding  = J_TYPE;
                dec_ctrl.is_branch = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            (opcode == OP_JALR): begin
                dec_ctrl.encoding  = I_TYPE;
                dec_ctrl.is_branch = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                if (funct3 != 3'b000)
                    dec_ill = 1'b1;
            end
            (opcode == OP_LUI): begin
                dec_ctrl.encoding  = U_TYPE;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_LUI;
            end
            (opcode == OP_AUIPC): begin
                dec_ctrl.encoding  = U_TYPE;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill)
            dec_ctrl = '0;
    end

    assign in_ready  = (cnt_q < CNT_W'(DEPTH)) | out_ready;
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Next-state for the FIFO: flush wins, otherwise write at tail and read at head.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = '{instr: in_instr, pc: in_pc,
                                ctrl: dec_ctrl, ill: dec_ill};
                wr_d = ptr_nxt(wr_q);
            end
            if (pop)
                rd_d = ptr_nxt(rd_q);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO state registers; reset clears every stored entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head        = mem_q[rd_q];
    assign out_instr   = head.instr;
    assign out_pc      = head.pc;
    assign out_control = head.ctrl;
    assign out_illegal = head.ill;
    assign count       = cnt_q;

endmodule
